// File: rtl/quad_input_filter.sv
// quad_input_filter
// Conditions raw quadrature encoder pins: a two-flop synchronizer per channel,
// then a stability filter that only passes a value once it has disagreed with
// the current output for FILTER_LEN consecutive cycles. Simultaneous A/B output
// changes are illegal in quadrature and are flagged and counted.
module quad_input_filter #(
    parameter int FILTER_LEN = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr_err,
    input  logic             enc_a_raw,
    input  logic             enc_b_raw,
    output logic             enc_a,
    output logic             enc_b,
    output logic             valid,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0]       CNT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        FILL,
        LOAD,
        RUN
    } state_t;

    state_t     state;
    logic [1:0] fill_cnt;
    logic       sa1;
    logic       sa2;
    logic       sb1;
    logic       sb2;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic       flip_a;
    logic       flip_b;
    logic       err_detect;

    // Two-flop synchronizers, free-running regardless of state or enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa1 <= 1'b0;
            sa2 <= 1'b0;
            sb1 <= 1'b0;
            sb2 <= 1'b0;
        end else begin
            sa1 <= enc_a_raw;
            sa2 <= sa1;
            sb1 <= enc_b_raw;
            sb2 <= sb1;
        end
    end

    // A channel flips on this edge when its filter count has run out.
    always_comb begin
        flip_a = 1'b0;
        flip_b = 1'b0;
        if (state == RUN && enable) begin
            flip_a = (sa2 != enc_a) && (cnt_a == CNT_LAST);
            flip_b = (sb2 != enc_b) && (cnt_b == CNT_LAST);
        end
    end

    assign err_detect = flip_a & flip_b;

    // Startup sequencing, per-channel stability filters and the error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= 2'd0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            valid     <= 1'b0;
            cnt_a     <= 8'd0;
            cnt_b     <= 8'd0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_detect;
            case (state)
                FILL: begin
                    fill_cnt <= fill_cnt + 2'd1;
                    if (fill_cnt == 2'd1) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    enc_a    <= sa2;
                    enc_b    <= sb2;
                    cnt_a    <= 8'd0;
                    cnt_b    <= 8'd0;
                    valid    <= 1'b1;
                    fill_cnt <= 2'd0;
                    state    <= RUN;
                end
                RUN: begin
                    if (enable) begin
                        if (sa2 == enc_a) begin
                            cnt_a <= 8'd0;
                        end else if (flip_a) begin
                            enc_a <= sa2;
                            cnt_a <= 8'd0;
                        end else begin
                            cnt_a <= cnt_a + 8'd1;
                        end
                        if (sb2 == enc_b) begin
                            cnt_b <= 8'd0;
                        end else if (flip_b) begin
                            enc_b <= sb2;
                            cnt_b <= 8'd0;
                        end else begin
                            cnt_b <= cnt_b + 8'd1;
                        end
                    end else begin
                        cnt_a <= 8'd0;
                        cnt_b <= 8'd0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Saturating illegal-transition counter; a clear is applied before the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= ERR_W'(err_detect);
        end else if (err_detect && err_count != ERR_MAX) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_quad_input_filter.sv
// Testbench for quad_input_filter: directed scenarios plus a randomized run,
// checked against a history-based model of the filter behaviour.
module tb_quad_input_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clr_err;
    logic        enc_a_raw;
    logic        enc_b_raw;

    logic        enc_a, enc_b, valid, err_pulse;
    logic [15:0] err_count;
    logic        sat_enc_a, sat_enc_b, sat_valid, sat_err_pulse;
    logic [1:0]  sat_err_count;
    logic        f1_enc_a, f1_enc_b, f1_valid, f1_err_pulse;
    logic [15:0] f1_err_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    quad_input_filter #(.FILTER_LEN(4), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
        .enc_a_raw(enc_a_raw), .enc_b_raw(enc_b_raw),
        .enc_a(enc_a), .enc_b(enc_b), .valid(valid),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    quad_input_filter #(.FILTER_LEN(4), .ERR_W(2)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
        .enc_a_raw(enc_a_raw), .enc_b_raw(enc_b_raw),
        .enc_a(sat_enc_a), .enc_b(sat_enc_b), .valid(sat_valid),
        .err_pulse(sat_err_pulse), .err_count(sat_err_count)
    );

    quad_input_filter #(.FILTER_LEN(1), .ERR_W(16)) dut_f1 (
        .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
        .enc_a_raw(enc_a_raw), .enc_b_raw(enc_b_raw),
        .enc_a(f1_enc_a), .enc_b(f1_enc_b), .valid(f1_valid),
        .err_pulse(f1_err_pulse), .err_count(f1_err_count)
    );

    // Reference model: pin/enable history per edge since reset. An output
    // takes the opposite value when the synchronized pin (pin sampled two
    // edges earlier) has disagreed with it on each of the last len enabled
    // RUN edges. Edge 2 loads the pins sampled at edge 0.
    logic pa   [0:8191];
    logic pb   [0:8191];
    logic en_h [0:8191];
    int   n;
    logic m_a4, m_b4, m_a1, m_b1, m_valid, m_err4, m_err1;
    int   m_cnt16, m_cnt2, m_cnt1;

    function automatic logic flip_due(input int len, input int edge_n, input logic cur,
                                      input logic ch_b, input logic en_now);
        logic en_j;
        logic pin_j;
        if (edge_n - len + 1 < 3) return 1'b0;
        for (int j = 0; j < len; j++) begin
            en_j  = (j == 0) ? en_now : en_h[edge_n - j];
            pin_j = ch_b ? pb[edge_n - j - 2] : pa[edge_n - j - 2];
            if (!en_j || pin_j == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic err_due(input int len, input int edge_n, input logic cur_a,
                                     input logic cur_b, input logic en_now);
        return flip_due(len, edge_n, cur_a, 1'b0, en_now) && flip_due(len, edge_n, cur_b, 1'b1, en_now);
    endfunction

    // Model update on every clock edge, restarted by the asynchronous reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= 0;
            m_a4 <= 1'b0; m_b4 <= 1'b0; m_a1 <= 1'b0; m_b1 <= 1'b0;
            m_valid <= 1'b0; m_err4 <= 1'b0; m_err1 <= 1'b0;
            m_cnt16 <= 0; m_cnt2 <= 0; m_cnt1 <= 0;
        end else begin
            pa[n]   <= enc_a_raw;
            pb[n]   <= enc_b_raw;
            en_h[n] <= enable;
            n       <= n + 1;
            if (n == 2) begin
                m_a4 <= pa[0]; m_b4 <= pb[0]; m_a1 <= pa[0]; m_b1 <= pb[0];
                m_valid <= 1'b1;
            end else begin
                m_a4 <= m_a4 ^ flip_due(4, n, m_a4, 1'b0, enable);
                m_b4 <= m_b4 ^ flip_due(4, n, m_b4, 1'b1, enable);
                m_a1 <= m_a1 ^ flip_due(1, n, m_a1, 1'b0, enable);
                m_b1 <= m_b1 ^ flip_due(1, n, m_b1, 1'b1, enable);
            end
            m_err4 <= err_due(4, n, m_a4, m_b4, enable);
            m_err1 <= err_due(1, n, m_a1, m_b1, enable);
            if (clr_err) begin
                m_cnt16 <= err_due(4, n, m_a4, m_b4, enable) ? 1 : 0;
                m_cnt2  <= err_due(4, n, m_a4, m_b4, enable) ? 1 : 0;
                m_cnt1  <= err_due(1, n, m_a1, m_b1, enable) ? 1 : 0;
            end else begin
                if (err_due(4, n, m_a4, m_b4, enable) && m_cnt16 < 65535) m_cnt16 <= m_cnt16 + 1;
                if (err_due(4, n, m_a4, m_b4, enable) && m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
                if (err_due(1, n, m_a1, m_b1, enable) && m_cnt1 < 65535) m_cnt1 <= m_cnt1 + 1;
            end
        end
    end

    // Outputs are all zero while reset is held.
    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; clr_err = 1'b0;
        enc_a_raw = 1'b1; enc_b_raw = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (enc_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_enc_a: got %b expected 0", enc_a); end
        tests_run++;
        if (enc_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_enc_b: got %b expected 0", enc_b); end
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        tests_run++;
        if (err_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err_pulse: got %b expected 0", err_pulse); end
        tests_run++;
        if (err_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); end
    endtask

    // Pins high through reset: valid low for two edges, then outputs load 1.
    task automatic test_startup();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (valid !== (i == 2)) begin tests_failed++; $display("[TB] FAIL startup_valid edge %0d: got %b expected %b", i, valid, (i == 2)); end
            if (i == 2) begin
                tests_run++;
                if (enc_a !== 1'b1 || enc_b !== 1'b1) begin tests_failed++; $display("[TB] FAIL startup_outputs: got %b%b expected 11", enc_a, enc_b); end
                tests_run++;
                if (f1_enc_a !== 1'b1 || f1_enc_b !== 1'b1) begin tests_failed++; $display("[TB] FAIL startup_f1_outputs: got %b%b expected 11", f1_enc_a, f1_enc_b); end
                tests_run++;
                if (err_count !== 16'd0 || err_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL startup_err: got %0d/%b expected 0/0", err_count, err_pulse); end
            end
        end
    endtask

    // A pin rise stable before edge k reaches enc_a at edge k+5 (k+2 when FILTER_LEN=1).
    task automatic test_latency();
        enc_a_raw = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (enc_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL latency_setup: got %b expected 0", enc_a); end
        enc_a_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (enc_a !== (i >= 5)) begin tests_failed++; $display("[TB] FAIL latency_enc_a edge k+%0d: got %b expected %b", i, enc_a, (i >= 5)); end
            tests_run++;
            if (f1_enc_a !== (i >= 2)) begin tests_failed++; $display("[TB] FAIL latency_f1_enc_a edge k+%0d: got %b expected %b", i, f1_enc_a, (i >= 2)); end
        end
    endtask

    // A 3-cycle pulse on B is rejected and leaves no residual count behind.
    task automatic test_glitch();
        enc_b_raw = 1'b0;
        repeat (10) @(negedge clk);
        enc_b_raw = 1'b1;
        repeat (3) @(negedge clk);
        enc_b_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (enc_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL glitch_enc_b cycle %0d: got %b expected 0", i, enc_b); end
        end
        enc_b_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (enc_b !== (i >= 5)) begin tests_failed++; $display("[TB] FAIL glitch_recover edge k+%0d: got %b expected %b", i, enc_b, (i >= 5)); end
        end
    endtask

    // Both pins toggle together: one-cycle err_pulse, count 0->1; clear plus error gives 1.
    task automatic test_illegal();
        enc_a_raw = 1'b0;
        enc_b_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++;
            if (enc_a !== (i < 5) || enc_b !== (i < 5)) begin tests_failed++; $display("[TB] FAIL illegal_outputs edge k+%0d: got %b%b expected %b%b", i, enc_a, enc_b, (i < 5), (i < 5)); end
            tests_run++;
            if (err_pulse !== (i == 5)) begin tests_failed++; $display("[TB] FAIL illegal_err_pulse edge k+%0d: got %b expected %b", i, err_pulse, (i == 5)); end
            tests_run++;
            if (err_count !== ((i >= 5) ? 16'd1 : 16'd0)) begin tests_failed++; $display("[TB] FAIL illegal_err_count edge k+%0d: got %0d expected %0d", i, err_count, (i >= 5)); end
        end
        enc_a_raw = 1'b1;
        enc_b_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clr_err = (i == 4);
            tests_run++;
            if (err_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL clr_with_err_count edge k+%0d: got %0d expected 1", i, err_count); end
            tests_run++;
            if (err_pulse !== (i == 5)) begin tests_failed++; $display("[TB] FAIL clr_with_err_pulse edge k+%0d: got %b expected %b", i, err_pulse, (i == 5)); end
        end
        clr_err = 1'b0;
    endtask

    // Two-bit counter saturates at 3 over five illegal transitions.
    task automatic test_saturation();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        tests_run++;
        if (err_count !== 16'd0 || sat_err_count !== 2'd0) begin tests_failed++; $display("[TB] FAIL sat_clear: got %0d/%0d expected 0/0", err_count, sat_err_count); end
        for (int j = 1; j <= 5; j++) begin
            enc_a_raw = ~enc_a_raw;
            enc_b_raw = ~enc_b_raw;
            repeat (8) @(negedge clk);
            tests_run++;
            if (sat_err_count !== 2'((j > 3) ? 3 : j)) begin tests_failed++; $display("[TB] FAIL sat_count after %0d: got %0d expected %0d", j, sat_err_count, (j > 3) ? 3 : j); end
            tests_run++;
            if (err_count !== 16'(j)) begin tests_failed++; $display("[TB] FAIL wide_count after %0d: got %0d expected %0d", j, err_count, j); end
        end
    endtask

    // With enable low the outputs hold and no error fires; re-enabling
    // lets the already-changed pins through FILTER_LEN edges later.
    task automatic test_enable();
        enable = 1'b0;
        enc_a_raw = ~enc_a;
        enc_b_raw = ~enc_b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (enc_a !== ~enc_a_raw || enc_b !== ~enc_b_raw) begin tests_failed++; $display("[TB] FAIL enable_hold cycle %0d: got %b%b expected %b%b", i, enc_a, enc_b, ~enc_a_raw, ~enc_b_raw); end
            tests_run++;
            if (err_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL enable_no_err cycle %0d: got %b expected 0", i, err_pulse); end
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (enc_a !== (i >= 3 ? enc_a_raw : ~enc_a_raw)) begin tests_failed++; $display("[TB] FAIL enable_resume edge e+%0d: got %b expected %b", i, enc_a, (i >= 3 ? enc_a_raw : ~enc_a_raw)); end
            tests_run++;
            if (err_pulse !== (i == 3)) begin tests_failed++; $display("[TB] FAIL enable_resume_err edge e+%0d: got %b expected %b", i, err_pulse, (i == 3)); end
        end
    endtask

    // Reset mid-operation clears everything at once and startup repeats.
    task automatic test_reset_mid();
        logic pin_a;
        logic pin_b;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (valid !== 1'b0 || enc_a !== 1'b0 || enc_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mid_async: got v=%b out=%b%b expected v=0 out=00", valid, enc_a, enc_b); end
        tests_run++;
        if (err_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_mid_count: got %0d expected 0", err_count); end
        @(negedge clk);
        pin_a = 1'($urandom_range(0, 1));
        pin_b = 1'($urandom_range(0, 1));
        enc_a_raw = pin_a;
        enc_b_raw = pin_b;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (valid !== (i == 2)) begin tests_failed++; $display("[TB] FAIL restart_valid edge %0d: got %b expected %b", i, valid, (i == 2)); end
        end
        tests_run++;
        if (enc_a !== pin_a || enc_b !== pin_b || err_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_load: got %b%b/%b expected %b%b/0", enc_a, enc_b, err_pulse, pin_a, pin_b); end
    endtask

    // Randomized pins (including simultaneous toggles and short glitches),
    // enable gaps and clear pulses, checked each cycle against the model.
    task automatic test_random();
        int hold = 0;
        int en_hold = 0;
        int r;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            tests_run++;
            if (enc_a !== m_a4 || enc_b !== m_b4) begin tests_failed++; $display("[TB] FAIL rand_outputs cycle %0d: got %b%b expected %b%b", c, enc_a, enc_b, m_a4, m_b4); end
            tests_run++;
            if (valid !== m_valid || err_pulse !== m_err4) begin tests_failed++; $display("[TB] FAIL rand_valid_err cycle %0d: got %b/%b expected %b/%b", c, valid, err_pulse, m_valid, m_err4); end
            tests_run++;
            if (err_count !== 16'(m_cnt16)) begin tests_failed++; $display("[TB] FAIL rand_err_count cycle %0d: got %0d expected %0d", c, err_count, m_cnt16); end
            tests_run++;
            if (sat_err_count !== 2'(m_cnt2) || sat_enc_a !== m_a4 || sat_enc_b !== m_b4 || sat_valid !== m_valid || sat_err_pulse !== m_err4) begin
                tests_failed++; $display("[TB] FAIL rand_sat cycle %0d: got cnt=%0d out=%b%b expected cnt=%0d out=%b%b", c, sat_err_count, sat_enc_a, sat_enc_b, m_cnt2, m_a4, m_b4);
            end
            tests_run++;
            if (f1_enc_a !== m_a1 || f1_enc_b !== m_b1 || f1_err_pulse !== m_err1 || f1_valid !== m_valid || f1_err_count !== 16'(m_cnt1)) begin
                tests_failed++; $display("[TB] FAIL rand_f1 cycle %0d: got out=%b%b err=%b cnt=%0d expected out=%b%b err=%b cnt=%0d", c, f1_enc_a, f1_enc_b, f1_err_pulse, f1_err_count, m_a1, m_b1, m_err1, m_cnt1);
            end
            if (hold == 0) begin
                r = int'($urandom_range(0, 99));
                if (r < 30) begin
                    enc_a_raw = ~enc_a_raw;
                    enc_b_raw = ~enc_b_raw;
                end else if (r < 65) begin
                    enc_a_raw = ~enc_a_raw;
                end else begin
                    enc_b_raw = ~enc_b_raw;
                end
                hold = int'($urandom_range(1, 8));
            end else begin
                hold--;
            end
            if (en_hold == 0) begin
                enable = ($urandom_range(0, 7) != 0);
                en_hold = int'($urandom_range(1, 12));
            end else begin
                en_hold--;
            end
            clr_err = ($urandom_range(0, 39) == 0);
        end
        clr_err = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_latency();
        test_glitch();
        test_illegal();
        test_saturation();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against the run never reaching its summary.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
